// File: rtl/entropy_encoder_ctrl_if.sv
// Op-word source bus into entropy_encoder_ctrl: valid/ready handshake plus one encoder op word.
interface entropy_encoder_ctrl_if #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [RANGE_WIDTH-1:0]  in_fl;
  logic [RANGE_WIDTH-1:0]  in_fh;
  logic [SYMBOL_WIDTH-1:0] in_symbol_1;
  logic [SYMBOL_WIDTH-1:0] in_symbol_2;
  logic [SYMBOL_WIDTH:0]   in_nsyms;
  logic                    in_bool_1;
  logic                    in_bool_2;
  logic                    in_last;

  modport master (
    output in_valid, in_fl, in_fh, in_symbol_1, in_symbol_2, in_nsyms, in_bool_1, in_bool_2, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_fl, in_fh, in_symbol_1, in_symbol_2, in_nsyms, in_bool_1, in_bool_2, in_last,
    output in_ready
  );
endinterface

// File: rtl/entropy_encoder_ctrl.sv
// Frame sequencer: buffers one frame of encoder ops and replays them gap-free with first/final flags.
// Optional ENC_CTRL_STATS_EN adds stat_frames / stat_ops counters.
module entropy_encoder_ctrl #(
  parameter int RANGE_WIDTH   = 16,
  parameter int SYMBOL_WIDTH  = 4,
  parameter int FIFO_AW       = 4,
  parameter int START_LEVEL   = 12,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                    top_clk,
  input  logic                    top_reset,
  entropy_encoder_ctrl_if.slave   op,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  output logic                    enc_bool_1,
  output logic                    enc_bool_2,
  output logic                    enc_flag_first,
  output logic                    enc_final_flag,
  input  logic                    enc_flag_last,
  output logic                    busy,
  output logic                    err_underrun,
  output logic                    err_timeout
`ifdef ENC_CTRL_STATS_EN
  ,
  output logic [15:0]             stat_frames,
  output logic [31:0]             stat_ops
`endif
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [FIFO_AW:0] DEPTH_V   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] START_V   = (FIFO_AW + 1)'(START_LEVEL);
  localparam logic [CW-1:0]    DRAIN_MAX = CW'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, FINAL, DRAIN, ERR} state_t;

  typedef struct packed {
    logic [RANGE_WIDTH-1:0]  fl;
    logic [RANGE_WIDTH-1:0]  fh;
    logic [SYMBOL_WIDTH-1:0] symbol_1;
    logic [SYMBOL_WIDTH-1:0] symbol_2;
    logic [SYMBOL_WIDTH:0]   nsyms;
    logic                    bool_1;
    logic                    bool_2;
    logic                    last;
  } op_t;

  op_t              mem_r [DEPTH];
  state_t           state_r;
  logic [FIFO_AW:0] wr_ptr_r;
  logic [FIFO_AW:0] rd_ptr_r;
  logic             last_acc_r;
  logic             first_r;
  logic [CW-1:0]    drain_cnt_r;

  logic [FIFO_AW:0] occ_s;
  logic             full_s;
  logic             empty_s;
  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  op_t              wr_op_s;
  op_t              head_s;

  // The extra pointer bit separates full from empty when the low bits coincide.
  assign occ_s      = wr_ptr_r - rd_ptr_r;
  assign full_s     = (occ_s == DEPTH_V);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign in_ready_s = !full_s && !last_acc_r && (state_r != ERR);
  assign push_s     = op.in_valid && in_ready_s;
  assign pop_s      = (state_r == STREAM) && !empty_s;
  assign head_s     = mem_r[rd_ptr_r[FIFO_AW-1:0]];
  assign op.in_ready = in_ready_s;
  assign busy       = (state_r != IDLE);

  assign wr_op_s = '{fl: op.in_fl, fh: op.in_fh, symbol_1: op.in_symbol_1, symbol_2: op.in_symbol_2,
                     nsyms: op.in_nsyms, bool_1: op.in_bool_1, bool_2: op.in_bool_2, last: op.in_last};

  // Op storage; contents are don't-care until written, so no reset.
  always_ff @(posedge top_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= wr_op_s;
    end
  end

  // Sequencer state, FIFO pointers, error flags and registered encoder outputs.
  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      state_r        <= IDLE;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      last_acc_r     <= 1'b0;
      first_r        <= 1'b0;
      drain_cnt_r    <= '0;
      enc_fl         <= '0;
      enc_fh         <= '0;
      enc_symbol_1   <= '0;
      enc_symbol_2   <= '0;
      enc_nsyms      <= '0;
      enc_bool_1     <= 1'b0;
      enc_bool_2     <= 1'b0;
      enc_flag_first <= 1'b0;
      enc_final_flag <= 1'b0;
      err_underrun   <= 1'b0;
      err_timeout    <= 1'b0;
`ifdef ENC_CTRL_STATS_EN
      stat_frames    <= 16'd0;
      stat_ops       <= 32'd0;
`endif
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
`ifdef ENC_CTRL_STATS_EN
        stat_ops <= stat_ops + 32'd1;
`endif
      end
      if (push_s && op.in_last) begin
        last_acc_r <= 1'b1;
      end
      // Encoder sees zeros unless a pop loads it this cycle.
      enc_fl         <= '0;
      enc_fh         <= '0;
      enc_symbol_1   <= '0;
      enc_symbol_2   <= '0;
      enc_nsyms      <= '0;
      enc_bool_1     <= 1'b0;
      enc_bool_2     <= 1'b0;
      enc_flag_first <= 1'b0;
      enc_final_flag <= 1'b0;
      case (state_r)
        IDLE: begin
          if (push_s) begin
            state_r <= FILL;
          end
        end
        FILL: begin
          first_r <= 1'b1;
          if ((occ_s >= START_V) || last_acc_r) begin
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (pop_s) begin
            enc_fl         <= head_s.fl;
            enc_fh         <= head_s.fh;
            enc_symbol_1   <= head_s.symbol_1;
            enc_symbol_2   <= head_s.symbol_2;
            enc_nsyms      <= head_s.nsyms;
            enc_bool_1     <= head_s.bool_1;
            enc_bool_2     <= head_s.bool_2;
            enc_flag_first <= first_r;
            first_r        <= 1'b0;
            if (head_s.last) begin
              state_r <= FINAL;
            end
          end else begin
            state_r      <= ERR;
            err_underrun <= 1'b1;
          end
        end
        FINAL: begin
          enc_final_flag <= 1'b1;
          drain_cnt_r    <= '0;
          state_r        <= DRAIN;
        end
        DRAIN: begin
          if (enc_flag_last) begin
            state_r    <= IDLE;
            last_acc_r <= 1'b0;
`ifdef ENC_CTRL_STATS_EN
            stat_frames <= stat_frames + 16'd1;
`endif
          end else if (drain_cnt_r == DRAIN_MAX) begin
            state_r     <= ERR;
            err_timeout <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 1'b1;
          end
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_encoder_ctrl.sv
// Randomized self-checking bench for entropy_encoder_ctrl against a queue-based frame model.
`timescale 1ns/1ps
module tb_entropy_encoder_ctrl;
  localparam int RW  = 16;
  localparam int SW  = 4;
  localparam int OPW = 2 * RW + 3 * SW + 1 + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_flag_last = 1'b0;
  logic [RW-1:0] enc_fl, enc_fh;
  logic [SW-1:0] enc_symbol_1, enc_symbol_2;
  logic [SW:0]   enc_nsyms;
  logic enc_bool_1, enc_bool_2, enc_flag_first, enc_final_flag, busy, err_underrun, err_timeout;
`ifdef ENC_CTRL_STATS_EN
  logic [15:0] stat_frames;
  logic [31:0] stat_ops;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  entropy_encoder_ctrl_if #(.RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW)) op_if ();

  entropy_encoder_ctrl #(
    .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .FIFO_AW(4), .START_LEVEL(12), .DRAIN_TIMEOUT(64)
  ) dut (
    .top_clk(clk), .top_reset(rst_n), .op(op_if),
    .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_symbol_1(enc_symbol_1), .enc_symbol_2(enc_symbol_2),
    .enc_nsyms(enc_nsyms), .enc_bool_1(enc_bool_1), .enc_bool_2(enc_bool_2),
    .enc_flag_first(enc_flag_first), .enc_final_flag(enc_final_flag), .enc_flag_last(enc_flag_last),
    .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout)
`ifdef ENC_CTRL_STATS_EN
    , .stat_frames(stat_frames), .stat_ops(stat_ops)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OPW-1:0] enc_word;
  assign enc_word = {enc_fl, enc_fh, enc_symbol_1, enc_symbol_2, enc_nsyms, enc_bool_1, enc_bool_2};

  // Model: ops in accepted order, their acceptance edges, and a per-cycle log of encoder outputs.
  typedef struct { int c; logic [OPW-1:0] d; logic f; logic fin; } rec_t;
  rec_t           log_q[$];
  logic [OPW-1:0] exp_ops[$];
  int             acc_q[$];

  always @(negedge clk) log_q.push_back('{cyc, enc_word, enc_flag_first, enc_final_flag});

  task automatic clear_model();
    log_q.delete();
    exp_ops.delete();
    acc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op_if.in_valid = 1'b0;
    enc_flag_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_model();
  endtask

  task automatic send_ops(input int n, input bit with_last, input int max_gap, output bit ok);
    logic [OPW-1:0] w;
    int waits;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ((max_gap > 0) ? $urandom_range(max_gap, 0) : 0) begin
        @(negedge clk);
        op_if.in_valid = 1'b0;
      end
      @(negedge clk);
      w = OPW'({$urandom(), $urandom()});
      {op_if.in_fl, op_if.in_fh, op_if.in_symbol_1, op_if.in_symbol_2, op_if.in_nsyms,
       op_if.in_bool_1, op_if.in_bool_2} = w;
      op_if.in_last  = with_last && (i == n - 1);
      op_if.in_valid = 1'b1;
      waits = 0;
      while (!op_if.in_ready && waits < 200) begin
        @(negedge clk);
        waits++;
      end
      if (!op_if.in_ready) begin
        ok = 1'b0;
        op_if.in_valid = 1'b0;
        return;
      end
      acc_q.push_back(cyc + 1);
      exp_ops.push_back(w);
    end
    @(negedge clk);
    op_if.in_valid = 1'b0;
    op_if.in_last  = 1'b0;
  endtask

  task automatic wait_final(output bit seen, output int fcyc);
    seen = 1'b0;
    fcyc = -1;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (enc_final_flag) begin
        seen = 1'b1;
        fcyc = cyc;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_flag_last();
    @(negedge clk);
    enc_flag_last = 1'b1;
    @(negedge clk);
    enc_flag_last = 1'b0;
  endtask

  // Summarises the log: first-flag position/count, final position/count, matching op run length.
  function automatic void scan_log(output int fi, output int nf, output int nfin, output int fin_i,
                                   output int run);
    fi = -1; nf = 0; nfin = 0; fin_i = -1; run = 0;
    foreach (log_q[i]) begin
      if (log_q[i].f) begin nf++; if (fi < 0) fi = i; end
      if (log_q[i].fin) begin nfin++; if (fin_i < 0) fin_i = i; end
    end
    if (fi >= 0)
      while (run < exp_ops.size() && fi + run < log_q.size() && log_q[fi + run].d == exp_ops[run]) run++;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (op_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", op_if.in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (enc_word !== '0) begin n_fail++; $display("FAIL reset_enc_data: got %h expected 0", enc_word); end
    n_checks++; if ({enc_flag_first, enc_final_flag, err_underrun, err_timeout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {enc_flag_first, enc_final_flag, err_underrun, err_timeout}); end
`ifdef ENC_CTRL_STATS_EN
    n_checks++; if ({stat_frames, stat_ops} !== 48'd0) begin n_fail++; $display("FAIL reset_stats: got %h expected 0", {stat_frames, stat_ops}); end
`endif
  endtask

  // Sends one framed burst and checks order, flags and first-op latency against the model.
  task automatic check_frame(input string name, input int n, input int max_gap);
    bit ok, seen;
    int fcyc, fi, nf, nfin, fin_i, run;
    clear_model();
    send_ops(n, 1'b1, max_gap, ok);
    wait_final(seen, fcyc);
    scan_log(fi, nf, nfin, fin_i, run);
    n_checks++; if (!(ok && seen)) begin n_fail++; $display("FAIL %s_handshake: accepted=%0b final_seen=%0b expected 1 1", name, ok, seen); end
    n_checks++; if (run !== n) begin n_fail++; $display("FAIL %s_op_run: got %0d expected %0d", name, run, n); end
    n_checks++; if ({nf, nfin} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL %s_flag_counts: first=%0d final=%0d expected 1 1", name, nf, nfin); end
    n_checks++; if (fin_i !== fi + n) begin n_fail++; $display("FAIL %s_final_pos: got %0d expected %0d", name, fin_i, fi + n); end
    if (fi >= 0 && acc_q.size() > 0) begin
      n_checks++;
      if (log_q[fi].c !== acc_q[(n > 12 ? 12 : n) - 1] + 2) begin
        n_fail++; $display("FAIL %s_start_cycle: got %0d expected %0d", name, log_q[fi].c, acc_q[(n > 12 ? 12 : n) - 1] + 2); end
    end
    if (fin_i >= 0) begin
      n_checks++; if (log_q[fin_i].d !== '0) begin n_fail++; $display("FAIL %s_final_data: got %h expected 0", name, log_q[fin_i].d); end
    end
    n_checks++; if ({busy, op_if.in_ready} !== 2'b10) begin n_fail++; $display("FAIL %s_drain_state: busy/in_ready=%b expected 10", name, {busy, op_if.in_ready}); end
    repeat ($urandom_range(8, 0)) @(negedge clk);
    pulse_flag_last();
    n_checks++; if ({busy, op_if.in_ready} !== 2'b01) begin n_fail++; $display("FAIL %s_idle_after_last: busy/in_ready=%b expected 01", name, {busy, op_if.in_ready}); end
  endtask

  task automatic test_three_op();
    check_frame("three_op", 3, 0);
  endtask

  // Full-rate 20-op frame with a stray enc_flag_last pulse while streaming.
  task automatic test_full_rate();
    fork
      check_frame("full_rate", 20, 0);
      begin
        repeat (15) @(negedge clk);
        enc_flag_last = 1'b1;
        @(negedge clk);
        enc_flag_last = 1'b0;
      end
    join
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) check_frame((f == 0) ? "single_op" : "random_frame", (f == 0) ? 1 : $urandom_range(12, 2), 2);
  endtask

  task automatic test_underrun();
    bit ok;
    int ecyc, fi, nf, nfin, fin_i, run;
    clear_model();
    send_ops(12, 1'b0, 0, ok);
    ecyc = -1;
    for (int k = 0; k < 40 && ecyc < 0; k++) begin
      @(negedge clk);
      if (err_underrun) ecyc = cyc;
    end
    scan_log(fi, nf, nfin, fin_i, run);
    n_checks++; if (ecyc !== acc_q[11] + 14) begin n_fail++; $display("FAIL underrun_cycle: got %0d expected %0d", ecyc, acc_q[11] + 14); end
    n_checks++; if ({run, nf, nfin} !== {32'd12, 32'd1, 32'd0}) begin n_fail++; $display("FAIL underrun_stream: run=%0d first=%0d final=%0d expected 12 1 0", run, nf, nfin); end
    op_if.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if ({err_underrun, op_if.in_ready, busy, err_timeout} !== 4'b1010) begin
      n_fail++; $display("FAIL underrun_sticky: err/in_ready/busy/timeout=%b expected 1010", {err_underrun, op_if.in_ready, busy, err_timeout}); end
    do_reset();
    n_checks++; if ({err_underrun, op_if.in_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL underrun_reset: err/in_ready/busy=%b expected 010", {err_underrun, op_if.in_ready, busy}); end
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int fcyc, tcyc;
    clear_model();
    send_ops(3, 1'b1, 0, ok);
    wait_final(seen, fcyc);
    while (seen && cyc < fcyc + 60) @(negedge clk);
    n_checks++; if ({seen, err_timeout, busy} !== 3'b101) begin n_fail++; $display("FAIL timeout_early: seen/err/busy=%b expected 101", {seen, err_timeout, busy}); end
    tcyc = -1;
    for (int k = 0; k < 30 && tcyc < 0; k++) begin
      @(negedge clk);
      if (err_timeout) tcyc = cyc;
    end
    n_checks++; if ({tcyc >= 0, op_if.in_ready, err_underrun} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_flag: raised/in_ready/underrun=%b expected 100", {tcyc >= 0, op_if.in_ready, err_underrun}); end
    pulse_flag_last();
    n_checks++; if ({err_timeout, busy} !== 2'b11) begin n_fail++; $display("FAIL timeout_stuck: err/busy=%b expected 11", {err_timeout, busy}); end
    do_reset();
    n_checks++; if ({err_timeout, err_underrun, op_if.in_ready, busy} !== 4'b0010) begin
      n_fail++; $display("FAIL timeout_reset: %b expected 0010", {err_timeout, err_underrun, op_if.in_ready, busy}); end
  endtask

  // 16 ops at full rate: concurrent push/pop must keep the FIFO below full so no op waits.
  task automatic test_back_to_back();
    bit ok;
    int fi, nf, nfin, fin_i, run;
    clear_model();
    send_ops(16, 1'b0, 0, ok);
    repeat (30) @(negedge clk);
    scan_log(fi, nf, nfin, fin_i, run);
    n_checks++; if (!ok || acc_q[15] - acc_q[0] !== 15) begin n_fail++; $display("FAIL b2b_accept_span: got %0d expected 15", ok ? acc_q[15] - acc_q[0] : -1); end
    n_checks++; if (run !== 16) begin n_fail++; $display("FAIL b2b_op_run: got %0d expected 16", run); end
    n_checks++; if ({err_underrun, op_if.in_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_end_underrun: err/in_ready=%b expected 10", {err_underrun, op_if.in_ready}); end
    do_reset();
  endtask

`ifdef ENC_CTRL_STATS_EN
  task automatic test_stats();
    int total;
    do_reset();
    check_frame("stats_f5", 5, 1);
    total = exp_ops.size();
    check_frame("stats_f7", 7, 1);
    total += exp_ops.size();
    n_checks++; if (stat_frames !== 16'd2) begin n_fail++; $display("FAIL stat_frames: got %0d expected 2", stat_frames); end
    n_checks++; if (stat_ops !== 32'(total)) begin n_fail++; $display("FAIL stat_ops: got %0d expected %0d", stat_ops, total); end
  endtask
`endif

  initial begin
    op_if.in_valid = 1'b0;
    op_if.in_last  = 1'b0;
    {op_if.in_fl, op_if.in_fh, op_if.in_symbol_1, op_if.in_symbol_2, op_if.in_nsyms,
     op_if.in_bool_1, op_if.in_bool_2} = '0;
    test_reset();
    test_three_op();
    test_full_rate();
    test_random_frames();
    test_underrun();
    test_timeout();
    test_back_to_back();
`ifdef ENC_CTRL_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
